dm_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters.
- Requester 0 is the CPU memory stage. Requester 1 is a loader/debug port.
- Selects one access per cycle and drives the memory's write-enable, address and write-data inputs.
- Captures the memory's combinational read data into a registered per-requester response with a valid strobe one cycle later.

---
 rtl/dm_arbiter.sv | 142 ++++++++++++++
 tb/tb_dm_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-requester arbiter in front of a single-port data memory, with registered read responses.
// Build option: define DM_ARB_CPU_PRIO_EN for fixed CPU priority instead of round-robin.
module dm_arbiter #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 128
) (
    input  logic          CLK,
    input  logic          RST,

    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    output logic          r0_err,

    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic          r1_err,

    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_din,
    input  logic [DW-1:0] dm_dout
);

    localparam logic [AW-1:0] ADDR_LIMIT = AW'(DEPTH * 4);

    function automatic logic addr_legal(input logic [AW-1:0] a);
        return (a[1:0] == 2'b00) && (a < ADDR_LIMIT);
    endfunction

    logic          any_req;
    logic          win_vld;
    logic          win_idx;
    logic          win_we;
    logic          win_legal;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    logic          r0_rvalid_q, r0_rvalid_d;
    logic          r0_err_q,    r0_err_d;
    logic [DW-1:0] r0_rdata_q,  r0_rdata_d;
    logic          r1_rvalid_q, r1_rvalid_d;
    logic          r1_err_q,    r1_err_d;
    logic [DW-1:0] r1_rdata_q,  r1_rdata_d;

`ifndef DM_ARB_CPU_PRIO_EN
    logic          both_req;
    logic          rr_ptr_q, rr_ptr_d;
`endif

    // Winner selection; a cycle with RST high grants nobody.
    always_comb begin
        any_req = r0_req | r1_req;
        win_vld = any_req & ~RST;
`ifdef DM_ARB_CPU_PRIO_EN
        win_idx = ~r0_req;
`else
        both_req = r0_req & r1_req;
        win_idx  = both_req ? rr_ptr_q : ~r0_req;
`endif
        win_we    = win_idx ? r1_we    : r0_we;
        win_addr  = win_idx ? r1_addr  : r0_addr;
        win_wdata = win_idx ? r1_wdata : r0_wdata;
        win_legal = addr_legal(win_addr);
    end

    assign r0_gnt  = win_vld & ~win_idx;
    assign r1_gnt  = win_vld &  win_idx;
    assign dm_we   = win_vld & win_we & win_legal;
    assign dm_addr = win_vld ? win_addr  : '0;
    assign dm_din  = win_vld ? win_wdata : '0;

`ifndef DM_ARB_CPU_PRIO_EN
    // Loser of a contended cycle gets priority next time.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (win_vld && both_req) begin
            rr_ptr_d = ~win_idx;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Response next state: illegal reads return zero data alongside err.
    always_comb begin
        r0_rvalid_d = r0_gnt & ~win_we;
        r0_err_d    = r0_gnt & ~win_legal;
        r0_rdata_d  = r0_rdata_q;
        if (r0_rvalid_d) begin
            r0_rdata_d = win_legal ? dm_dout : '0;
        end
        r1_rvalid_d = r1_gnt & ~win_we;
        r1_err_d    = r1_gnt & ~win_legal;
        r1_rdata_d  = r1_rdata_q;
        if (r1_rvalid_d) begin
            r1_rdata_d = win_legal ? dm_dout : '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r0_rvalid_q <= 1'b0;
            r0_err_q    <= 1'b0;
            r0_rdata_q  <= '0;
            r1_rvalid_q <= 1'b0;
            r1_err_q    <= 1'b0;
            r1_rdata_q  <= '0;
        end else begin
            r0_rvalid_q <= r0_rvalid_d;
            r0_err_q    <= r0_err_d;
            r0_rdata_q  <= r0_rdata_d;
            r1_rvalid_q <= r1_rvalid_d;
            r1_err_q    <= r1_err_d;
            r1_rdata_q  <= r1_rdata_d;
        end
    end

    assign r0_rvalid = r0_rvalid_q;
    assign r0_err    = r0_err_q;
    assign r0_rdata  = r0_rdata_q;
    assign r1_rvalid = r1_rvalid_q;
    assign r1_err    = r1_err_q;
    assign r1_rdata  = r1_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed vector table followed by randomized traffic against a reference model.
module tb_dm_arbiter;

    logic        CLK;
    logic        RST;
    logic        r0_req, r0_we, r0_gnt, r0_rvalid, r0_err;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic        r1_req, r1_we, r1_gnt, r1_rvalid, r1_err;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic        dm_we;
    logic [31:0] dm_addr, dm_din, dm_dout;

    dm_arbiter #(.DW(32), .AW(32), .DEPTH(128)) dut (
        .CLK(CLK), .RST(RST),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory the arbiter drives: combinational read, write on the clock edge.
    logic [31:0] mem [0:127];
    logic [6:0]  mem_idx;
    assign mem_idx = dm_addr[8:2];
    assign dm_dout = mem[mem_idx];
    always @(posedge CLK) if (dm_we) mem[mem_idx] <= dm_din;

    typedef struct {
        logic        rst;
        logic        q0, w0; logic [31:0] a0, d0;
        logic        q1, w1; logic [31:0] a1, d1;
        logic        g0, g1, we;
        logic        rv0; logic [31:0] rd0; logic e0;
        logic        rv1; logic [31:0] rd1; logic e1;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model state
    logic [31:0] mem_ref [0:127];
    int          m_ptr;
    logic        m_rv  [2];
    logic        m_err [2];
    logic [31:0] m_rd  [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rst,
                       input logic q0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic q1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic g0, input logic g1, input logic we,
                       input logic rv0, input logic [31:0] rd0, input logic e0,
                       input logic rv1, input logic [31:0] rd1, input logic e1);
        vec_t v;
        v.rst = rst;
        v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.we = we;
        v.rv0 = rv0; v.rd0 = rd0; v.e0 = e0;
        v.rv1 = rv1; v.rd1 = rd1; v.e1 = e1;
        tbl.push_back(v);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k == 0) return 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
        if (k == 1) return 32'(512 + $urandom_range(0, 1000) * 4);
        if (k == 2) return ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
        return 32'($urandom_range(0, 31) * 4);
    endfunction

    // Drive one cycle, check against table or model, then advance the model.
    task automatic apply(input vec_t v, input bit use_tbl, input string tag, output int win);
        logic        we, lg, exp_we;
        logic [31:0] a, d;
        @(negedge CLK);
        RST = v.rst;
        r0_req = v.q0; r0_we = v.w0; r0_addr = v.a0; r0_wdata = v.d0;
        r1_req = v.q1; r1_we = v.w1; r1_addr = v.a1; r1_wdata = v.d1;
        #1;
        if (v.rst || (!v.q0 && !v.q1)) win = -1;
        else if (v.q0 && !v.q1)         win = 0;
        else if (!v.q0 && v.q1)         win = 1;
`ifdef DM_ARB_CPU_PRIO_EN
        else                            win = 0;
`else
        else                            win = m_ptr;
`endif
        we = (win == 1) ? v.w1 : v.w0;
        a  = (win == 1) ? v.a1 : v.a0;
        d  = (win == 1) ? v.d1 : v.d0;
        lg = (a % 4 == 0) && (a < 512);
        exp_we = (win >= 0) && we && lg;

        if (use_tbl) begin
            chk({tag, " gnt0"},   32'(r0_gnt),    32'(v.g0));
            chk({tag, " gnt1"},   32'(r1_gnt),    32'(v.g1));
            chk({tag, " dm_we"},  32'(dm_we),     32'(v.we));
            chk({tag, " rvalid0"},32'(r0_rvalid), 32'(v.rv0));
            chk({tag, " rdata0"}, r0_rdata,       v.rd0);
            chk({tag, " err0"},   32'(r0_err),    32'(v.e0));
            chk({tag, " rvalid1"},32'(r1_rvalid), 32'(v.rv1));
            chk({tag, " rdata1"}, r1_rdata,       v.rd1);
            chk({tag, " err1"},   32'(r1_err),    32'(v.e1));
        end else begin
            chk({tag, " gnt0"},   32'(r0_gnt),    32'(win == 0));
            chk({tag, " gnt1"},   32'(r1_gnt),    32'(win == 1));
            chk({tag, " dm_we"},  32'(dm_we),     32'(exp_we));
            chk({tag, " rvalid0"},32'(r0_rvalid), 32'(m_rv[0]));
            chk({tag, " rdata0"}, r0_rdata,       m_rd[0]);
            chk({tag, " err0"},   32'(r0_err),    32'(m_err[0]));
            chk({tag, " rvalid1"},32'(r1_rvalid), 32'(m_rv[1]));
            chk({tag, " rdata1"}, r1_rdata,       m_rd[1]);
            chk({tag, " err1"},   32'(r1_err),    32'(m_err[1]));
            if (win >= 0) begin
                chk({tag, " dm_addr"}, dm_addr, a);
                if (exp_we) chk({tag, " dm_din"}, dm_din, d);
            end
        end

        m_rv[0] = 0; m_rv[1] = 0; m_err[0] = 0; m_err[1] = 0;
        if (v.rst) begin
            m_rd[0] = 0; m_rd[1] = 0; m_ptr = 0;
        end else if (win >= 0) begin
            m_err[win] = !lg;
            if (!we) begin
                m_rv[win] = 1;
                m_rd[win] = lg ? mem_ref[a / 4] : 32'h0;
            end else if (lg) begin
                mem_ref[a / 4] = d;
            end
            if (v.q0 && v.q1) m_ptr = 1 - win;
        end
    endtask

    initial begin
        vec_t rv;
        int   win;
        bit   pend0, pend1;

        for (int i = 0; i < 128; i++) begin mem[i] = 0; mem_ref[i] = 0; end
        m_ptr = 0;
        m_rv[0] = 0; m_rv[1] = 0; m_err[0] = 0; m_err[1] = 0; m_rd[0] = 0; m_rd[1] = 0;
        RST = 1;
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
        @(posedge CLK);

        //   rst  r0: q w addr data          r1: q w addr data          g0 g1 we  rv0 rd0 e0  rv1 rd1 e1
        add(1, 1,0,32'h0,  0,            1,0,32'h4,  0,            0,0,0, 0,32'h0,0, 0,32'h0,0);
        add(1, 1,0,32'h0,  0,            1,0,32'h4,  0,            0,0,0, 0,32'h0,0, 0,32'h0,0);
        add(0, 1,0,32'h0,  0,            1,0,32'h4,  0,            1,0,0, 0,32'h0,0, 0,32'h0,0);
        add(0, 0,0,32'h0,  0,            1,0,32'h4,  0,            0,1,0, 1,32'h0,0, 0,32'h0,0);
        add(0, 1,1,32'h10, 32'hDEADBEEF, 0,0,32'h0,  0,            1,0,1, 0,32'h0,0, 1,32'h0,0);
        add(0, 1,0,32'h10, 0,            0,0,32'h0,  0,            1,0,0, 0,32'h0,0, 0,32'h0,0);
        add(0, 0,0,32'h0,  0,            1,1,32'h8,  32'h12345678, 0,1,1, 1,32'hDEADBEEF,0, 0,32'h0,0);
`ifdef DM_ARB_CPU_PRIO_EN
        add(0, 1,0,32'h10, 0,            1,0,32'h8,  0,            1,0,0, 0,32'hDEADBEEF,0, 0,32'h0,0);
        add(0, 1,0,32'h10, 0,            1,0,32'h8,  0,            1,0,0, 1,32'hDEADBEEF,0, 0,32'h0,0);
        add(0, 1,0,32'h10, 0,            1,0,32'h8,  0,            1,0,0, 1,32'hDEADBEEF,0, 0,32'h0,0);
        add(0, 0,0,32'h0,  0,            1,0,32'h8,  0,            0,1,0, 1,32'hDEADBEEF,0, 0,32'h0,0);
        add(0, 0,0,32'h0,  0,            0,0,32'h0,  0,            0,0,0, 0,32'hDEADBEEF,0, 1,32'h12345678,0);
`else
        add(0, 1,0,32'h10, 0,            1,0,32'h8,  0,            0,1,0, 0,32'hDEADBEEF,0, 0,32'h0,0);
        add(0, 1,0,32'h10, 0,            1,0,32'h8,  0,            1,0,0, 0,32'hDEADBEEF,0, 1,32'h12345678,0);
        add(0, 1,0,32'h10, 0,            1,0,32'h8,  0,            0,1,0, 1,32'hDEADBEEF,0, 0,32'h12345678,0);
        add(0, 1,0,32'h10, 0,            1,0,32'h8,  0,            1,0,0, 0,32'hDEADBEEF,0, 1,32'h12345678,0);
        add(0, 0,0,32'h0,  0,            0,0,32'h0,  0,            0,0,0, 1,32'hDEADBEEF,0, 0,32'h12345678,0);
`endif
        add(0, 0,0,32'h0,  0,            1,1,32'h202,32'hCAFEF00D, 0,1,0, 0,32'hDEADBEEF,0, 0,32'h12345678,0);
        add(0, 0,0,32'h0,  0,            1,0,32'h200,0,            0,1,0, 0,32'hDEADBEEF,0, 0,32'h12345678,1);
        add(0, 0,0,32'h0,  0,            1,0,32'h0,  0,            0,1,0, 0,32'hDEADBEEF,0, 1,32'h0,1);
        add(0, 0,0,32'h0,  0,            0,0,32'h0,  0,            0,0,0, 0,32'hDEADBEEF,0, 1,32'h0,0);
        add(1, 1,0,32'h10, 0,            0,0,32'h0,  0,            0,0,0, 0,32'hDEADBEEF,0, 0,32'h0,0);
        add(0, 0,0,32'h0,  0,            0,0,32'h0,  0,            0,0,0, 0,32'h0,0, 0,32'h0,0);
        add(0, 0,0,32'h0,  0,            0,0,32'h0,  0,            0,0,0, 0,32'h0,0, 0,32'h0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], 1'b1, $sformatf("row%0d", i), win);
        end

        rv = '{default: 0};
        pend0 = 0; pend1 = 0;
        for (int n = 0; n < 3000; n++) begin
            rv.rst = ($urandom_range(0, 63) == 0);
            if (!pend0 && $urandom_range(0, 1) == 1) begin
                pend0 = 1; rv.w0 = 1'($urandom_range(0, 1)); rv.a0 = rand_addr(); rv.d0 = $urandom;
            end
            if (!pend1 && $urandom_range(0, 1) == 1) begin
                pend1 = 1; rv.w1 = 1'($urandom_range(0, 1)); rv.a1 = rand_addr(); rv.d1 = $urandom;
            end
            rv.q0 = pend0;
            rv.q1 = pend1;
            apply(rv, 1'b0, $sformatf("rnd%0d", n), win);
            if (win == 0) pend0 = 0;
            if (win == 1) pend1 = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
